load_store_unit: RTL and testbench

Memory-stage load/store initiator for the pipelined RV32I core. It takes a decoded access from the EX/MEM register and issues it as a valid/ready request on the data-memory port. It performs RV32I byte/half/word lane steering on stores and extraction/sign-extension on loads. It stalls the pipeline until the access completes, and flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store initiator: issues one valid/ready data-memory request
// per access, steers store lanes, extracts and extends load data, and stalls until done.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        lsu_fault_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_wstrb_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_resp_valid_i,
    input  logic [31:0] dmem_resp_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_data_q, load_data_d;

    logic        access;
    logic        bad_access;
    logic        start;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Illegal widths include the unsigned codes when used by a store.
    always_comb begin
        access     = mem_read_i | mem_write_i;
        bad_access = 1'b0;
        case (funct3_i)
            3'b011, 3'b110, 3'b111: bad_access = 1'b1;
            3'b100:                 bad_access = ~mem_read_i;
            3'b101:                 bad_access = ~mem_read_i | alu_result_i[0];
            3'b001:                 bad_access = alu_result_i[0];
            3'b010:                 bad_access = |alu_result_i[1:0];
            default:                bad_access = 1'b0;
        endcase
        lsu_fault_o = (state_q == IDLE) & req_valid_i & access & bad_access;
        start       = (state_q == IDLE) & req_valid_i & access & ~bad_access;
    end

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = rs2_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << alu_result_i[1:0];
                st_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                st_wstrb = alu_result_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = rs2_data_i;
            end
        endcase
    end

    always_comb begin
        shifted = dmem_resp_rdata_i >> {off_q, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = off_q[1] ? dmem_resp_rdata_i[31:16] : dmem_resp_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'b0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'b0, ld_half};
            default: ld_value = dmem_resp_rdata_i;
        endcase
    end

    // Request fields are only written on start, so they stay frozen while waiting for ready.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    we_d        = ~mem_read_i;
                    addr_d      = {alu_result_i[31:2], 2'b00};
                    wstrb_d     = mem_read_i ? 4'b0000 : st_wstrb;
                    wdata_d     = st_wdata;
                    funct3_d    = funct3_i;
                    off_d       = alu_result_i[1:0];
                end
            end
            REQ: begin
                if (dmem_req_ready_i) begin
                    req_valid_d = 1'b0;
                    state_d     = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (dmem_resp_valid_i) begin
                    load_data_d = ld_value;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'b0;
            wstrb_q     <= 4'b0;
            wdata_q     <= 32'b0;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            load_data_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
        end
    end

    assign stall_o          = start | (state_q == REQ) | (state_q == RESP);
    assign done_o           = (state_q == DONE);
    assign load_data_o      = load_data_q;
    assign dmem_req_valid_o = req_valid_q;
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wstrb_o     = wstrb_q;
    assign dmem_wdata_o     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: store lanes, load extension,
// backpressure, faults, back-to-back issue and mid-access reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluResult, rs2Data;
    logic        stall, done, lsuFault;
    logic [31:0] loadData;
    logic        dmemReqValid, dmemReqReady, dmemWe;
    logic [31:0] dmemAddr, dmemWdata;
    logic [3:0]  dmemWstrb;
    logic        dmemRespValid;
    logic [31:0] dmemRespRdata;

    int errors = 0;
    int checks = 0;
    int acceptCount = 0;

    load_store_unit dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .req_valid_i       (reqValid),
        .mem_read_i        (memRead),
        .mem_write_i       (memWrite),
        .funct3_i          (funct3),
        .alu_result_i      (aluResult),
        .rs2_data_i        (rs2Data),
        .stall_o           (stall),
        .done_o            (done),
        .load_data_o       (loadData),
        .lsu_fault_o       (lsuFault),
        .dmem_req_valid_o  (dmemReqValid),
        .dmem_req_ready_i  (dmemReqReady),
        .dmem_we_o         (dmemWe),
        .dmem_addr_o       (dmemAddr),
        .dmem_wstrb_o      (dmemWstrb),
        .dmem_wdata_o      (dmemWdata),
        .dmem_resp_valid_i (dmemRespValid),
        .dmem_resp_rdata_i (dmemRespRdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmemReqValid && dmemReqReady) acceptCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        reqValid = 0; memRead = 0; memWrite = 0; funct3 = 3'b000;
        aluResult = 0; rs2Data = 0; dmemReqReady = 0; dmemRespValid = 0; dmemRespRdata = 0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (lsuFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got=%b exp=0", lsuFault); end
        checks++; if (dmemReqValid !== 1'b0 || dmemWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got valid=%b we=%b exp=0,0", dmemReqValid, dmemWe); end
        checks++; if (dmemWstrb !== 4'b0000) begin errors++; $display("[TB] FAIL reset_wstrb got=%b exp=0000", dmemWstrb); end
        checks++; if (dmemAddr !== 32'h0 || dmemWdata !== 32'h0 || loadData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got addr=%h wdata=%h ld=%h exp=0", dmemAddr, dmemWdata, loadData); end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] expAddr,
                              input logic [3:0] expWstrb, input logic [31:0] expWdata);
        logic [31:0] ldBefore;
        ldBefore = loadData;
        reqValid = 1; memWrite = 1; memRead = 0; funct3 = f3; aluResult = addr; rs2Data = rs2; dmemReqReady = 1;
        #1;
        checks++; if (stall !== 1'b1 || lsuFault !== 1'b0) begin errors++; $display("[TB] FAIL %s_start got stall=%b fault=%b exp=1,0", name, stall, lsuFault); end
        @(negedge clk);
        reqValid = 0; memWrite = 0; aluResult = 0; rs2Data = 0;
        #1;
        checks++; if (dmemReqValid !== 1'b1 || dmemWe !== 1'b1 || stall !== 1'b1) begin errors++; $display("[TB] FAIL %s_req got valid=%b we=%b stall=%b exp=1,1,1", name, dmemReqValid, dmemWe, stall); end
        checks++; if (dmemAddr !== expAddr) begin errors++; $display("[TB] FAIL %s_addr got=%h exp=%h", name, dmemAddr, expAddr); end
        checks++; if (dmemWstrb !== expWstrb) begin errors++; $display("[TB] FAIL %s_wstrb got=%b exp=%b", name, dmemWstrb, expWstrb); end
        checks++; if (dmemWdata !== expWdata) begin errors++; $display("[TB] FAIL %s_wdata got=%h exp=%h", name, dmemWdata, expWdata); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || stall !== 1'b0 || dmemReqValid !== 1'b0) begin errors++; $display("[TB] FAIL %s_done got done=%b stall=%b valid=%b exp=1,0,0", name, done, stall, dmemReqValid); end
        checks++; if (loadData !== ldBefore) begin errors++; $display("[TB] FAIL %s_ldkeep got=%h exp=%h", name, loadData, ldBefore); end
        dmemReqReady = 0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_idle got done=%b exp=0", name, done); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] expData);
        reqValid = 1; memRead = 1; memWrite = 0; funct3 = f3; aluResult = addr; dmemReqReady = 1;
        #1;
        checks++; if (stall !== 1'b1 || lsuFault !== 1'b0) begin errors++; $display("[TB] FAIL %s_start got stall=%b fault=%b exp=1,0", name, stall, lsuFault); end
        @(negedge clk);
        reqValid = 0; memRead = 0; aluResult = 0;
        #1;
        checks++; if (dmemReqValid !== 1'b1 || dmemWe !== 1'b0 || dmemWstrb !== 4'b0000 || stall !== 1'b1) begin errors++; $display("[TB] FAIL %s_req got valid=%b we=%b wstrb=%b stall=%b exp=1,0,0000,1", name, dmemReqValid, dmemWe, dmemWstrb, stall); end
        checks++; if (dmemAddr !== {addr[31:2], 2'b00}) begin errors++; $display("[TB] FAIL %s_addr got=%h exp=%h", name, dmemAddr, {addr[31:2], 2'b00}); end
        @(negedge clk);
        dmemReqReady = 0; dmemRespValid = 1; dmemRespRdata = rdata;
        #1;
        checks++; if (stall !== 1'b1 || done !== 1'b0 || dmemReqValid !== 1'b0) begin errors++; $display("[TB] FAIL %s_resp got stall=%b done=%b valid=%b exp=1,0,0", name, stall, done, dmemReqValid); end
        @(negedge clk);
        dmemRespValid = 0; dmemRespRdata = 0;
        #1;
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL %s_done got done=%b stall=%b exp=1,0", name, done, stall); end
        checks++; if (loadData !== expData) begin errors++; $display("[TB] FAIL %s_data got=%h exp=%h", name, loadData, expData); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || loadData !== expData) begin errors++; $display("[TB] FAIL %s_hold got done=%b data=%h exp=0,%h", name, done, loadData, expData); end
    endtask

    task automatic test_backpressure();
        acceptCount = 0;
        reqValid = 1; memRead = 1; funct3 = 3'b010; aluResult = 32'h200; dmemReqReady = 0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL bp_start got stall=%b exp=1", stall); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reqValid = 0; memRead = 0; aluResult = 32'hFFFF_FFFF;
            dmemRespValid = (i == 0); dmemRespRdata = 32'hBAD0BAD0;
            #1;
            checks++; if (dmemReqValid !== 1'b1 || dmemAddr !== 32'h200 || dmemWe !== 1'b0 || dmemWstrb !== 4'b0000 || stall !== 1'b1) begin
                errors++; $display("[TB] FAIL bp_hold%0d got valid=%b addr=%h we=%b wstrb=%b stall=%b exp=1,00000200,0,0000,1", i, dmemReqValid, dmemAddr, dmemWe, dmemWstrb, stall);
            end
        end
        @(negedge clk);
        dmemReqReady = 1; dmemRespValid = 0;
        #1;
        checks++; if (dmemReqValid !== 1'b1 || dmemAddr !== 32'h200 || stall !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept got valid=%b addr=%h stall=%b exp=1,00000200,1", dmemReqValid, dmemAddr, stall); end
        @(negedge clk);
        dmemReqReady = 0;
        #1;
        checks++; if (stall !== 1'b1 || done !== 1'b0 || dmemReqValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_wait got stall=%b done=%b valid=%b exp=1,0,0", stall, done, dmemReqValid); end
        @(negedge clk);
        dmemRespValid = 1; dmemRespRdata = 32'hCAFEF00D;
        #1;
        checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL bp_resp got stall=%b done=%b exp=1,0", stall, done); end
        @(negedge clk);
        dmemRespValid = 0; dmemRespRdata = 0;
        #1;
        checks++; if (done !== 1'b1 || stall !== 1'b0 || loadData !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL bp_done got done=%b stall=%b data=%h exp=1,0,cafef00d", done, stall, loadData); end
        checks++; if (acceptCount !== 1) begin errors++; $display("[TB] FAIL bp_accepts got=%0d exp=1", acceptCount); end
        @(negedge clk);
    endtask

    task automatic test_fault();
        logic [2:0]  fF3[5]   = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b010};
        logic [31:0] fAddr[5] = '{32'h101, 32'h100, 32'h100, 32'h103, 32'h101};
        logic        fRd[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        fVal[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        fExp[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            reqValid = fVal[i]; memRead = fRd[i]; memWrite = ~fRd[i]; funct3 = fF3[i]; aluResult = fAddr[i]; dmemReqReady = 1;
            #1;
            checks++; if (lsuFault !== fExp[i] || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL fault%0d got fault=%b stall=%b done=%b exp=%b,0,0", i, lsuFault, stall, done, fExp[i]); end
            @(negedge clk);
            checks++; if (dmemReqValid !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL fault%0d_noreq got valid=%b stall=%b exp=0,0", i, dmemReqValid, stall); end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        reqValid = 1; memWrite = 1; memRead = 0; funct3 = 3'b010; aluResult = 32'h104; rs2Data = 32'h0BADF00D; dmemReqReady = 1;
        @(negedge clk);
        #1;
        checks++; if (dmemReqValid !== 1'b1 || dmemAddr !== 32'h104 || dmemWdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL b2b_req1 got valid=%b addr=%h wdata=%h exp=1,00000104,0badf00d", dmemReqValid, dmemAddr, dmemWdata); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_doneignore got done=%b stall=%b exp=1,0", done, stall); end
        @(negedge clk);
        funct3 = 3'b001; aluResult = 32'h102; rs2Data = 32'h1234ABCD;
        #1;
        checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start2 got stall=%b done=%b exp=1,0", stall, done); end
        @(negedge clk);
        reqValid = 0; memWrite = 0;
        #1;
        checks++; if (dmemAddr !== 32'h100 || dmemWstrb !== 4'b1100 || dmemWdata !== 32'hABCDABCD) begin errors++; $display("[TB] FAIL b2b_req2 got addr=%h wstrb=%b wdata=%h exp=00000100,1100,abcdabcd", dmemAddr, dmemWstrb, dmemWdata); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2 got=%b exp=1", done); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        reqValid = 1; memRead = 1; funct3 = 3'b010; aluResult = 32'h300; dmemReqReady = 1;
        @(negedge clk);
        reqValid = 0; memRead = 0;
        @(negedge clk);
        dmemReqReady = 0;
        #1;
        checks++; if (stall !== 1'b1 || dmemReqValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_inresp got stall=%b valid=%b exp=1,0", stall, dmemReqValid); end
        rstN = 1'b0;
        #1;
        checks++; if (dmemReqValid !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || lsuFault !== 1'b0 || dmemWe !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctrl got valid=%b stall=%b done=%b fault=%b we=%b exp=0", dmemReqValid, stall, done, lsuFault, dmemWe); end
        checks++; if (dmemAddr !== 32'h0 || dmemWstrb !== 4'b0 || dmemWdata !== 32'h0 || loadData !== 32'h0) begin errors++; $display("[TB] FAIL rmid_data got addr=%h wstrb=%b wdata=%h ld=%h exp=0", dmemAddr, dmemWstrb, dmemWdata, loadData); end
        @(negedge clk);
        rstN = 1'b1; dmemRespValid = 1; dmemRespRdata = 32'h55AA55AA;
        @(negedge clk);
        dmemRespValid = 0; dmemRespRdata = 0;
        #1;
        checks++; if (loadData !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late got ld=%h done=%b stall=%b exp=0,0,0", loadData, done, stall); end
        @(negedge clk);
        checks++; if (loadData !== 32'h0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after got ld=%h done=%b exp=0,0", loadData, done); end
    endtask

    initial begin
        test_reset();
        test_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        test_store("sb", 3'b000, 32'h103, 32'h000000A5, 32'h100, 4'b1000, 32'hA5A5A5A5);
        test_store("sh", 3'b001, 32'h200, 32'h89AB7654, 32'h200, 4'b0011, 32'h76547654);
        test_load("lb", 3'b000, 32'h102, 32'h1280FF34, 32'hFFFFFF80);
        test_load("lbu", 3'b100, 32'h102, 32'h1280FF34, 32'h00000080);
        test_load("lh", 3'b001, 32'h102, 32'h1280FF34, 32'h00001280);
        test_load("lhlo", 3'b001, 32'h100, 32'h1280FF34, 32'hFFFFFF34);
        test_load("lhu", 3'b101, 32'h100, 32'h1280FF34, 32'h0000FF34);
        test_store("sbkeep", 3'b000, 32'h101, 32'h0000003C, 32'h100, 4'b0010, 32'h3C3C3C3C);
        test_backpressure();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
